// File: rtl/fir_decim_buffer.sv
// rtl/fir_decim_buffer.sv - decimating FWFT sample FIFO behind the FIR filter
// Define FIR_DECIM_AVG_EN to emit group averages instead of picking every DECIM-th sample.
module fir_decim_buffer #(
  parameter int DECIM = 4,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [15:0]            in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            drop_cnt,
  input  logic                   clr_ovf
);

  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [PW-1:0] phase;
  logic          phase_last;
  logic          keep;
  logic [15:0]   keep_data;

  assign phase_last = (phase == PW'(DECIM - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (in_valid) begin
      phase <= phase_last ? '0 : phase + PW'(1);
    end
  end

`ifdef FIR_DECIM_AVG_EN
  localparam int SH   = $clog2(DECIM);
  localparam int ACCW = 16 + SH;

  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] base;
  logic signed [ACCW-1:0] sum;

  // A full group of 16-bit samples always fits in ACCW bits, so no saturation is needed.
  assign base      = (phase == '0) ? '0 : acc;
  assign sum       = base + ACCW'($signed(in_data));
  assign keep      = in_valid & phase_last;
  assign keep_data = 16'(sum >>> SH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (in_valid) begin
      acc <= sum;
    end
  end
`else
  assign keep      = in_valid & (phase == '0);
  assign keep_data = in_data;
`endif

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // A pop in the same cycle frees the slot, so a full FIFO can still take the sample.
  assign full = (level == LW'(DEPTH));
  assign pop  = out_valid & out_ready;
  assign push = keep & (~full | pop);
  assign drop = keep & full & ~pop;

  assign out_valid = (level != '0);
  assign out_data  = out_valid ? mem[rptr] : 16'h0000;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= keep_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // A drop in the same cycle as clr_ovf wins, restarting the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= 16'h0000;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)
        drop_cnt <= 16'd1;
      else if (drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= 16'h0000;
    end
  end

endmodule

// File: tb/tb_fir_decim_buffer.sv
// tb/tb_fir_decim_buffer.sv - self-checking bench for fir_decim_buffer
// Two instances: u_d0 (DECIM=4, DEPTH=16) and u_d1 (DECIM=1, DEPTH=4).
module tb_fir_decim_buffer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv [2];
  logic        rd [2];
  logic        clr [2];
  logic [15:0] id [2];

  logic        ov0, ov1, of0, of1;
  logic [15:0] od0, od1, dc0, dc1;
  logic [4:0]  lv0;
  logic [2:0]  lv1;

  fir_decim_buffer #(.DECIM(4), .DEPTH(16)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]),
    .out_valid(ov0), .out_ready(rd[0]), .out_data(od0), .level(lv0),
    .overflow(of0), .drop_cnt(dc0), .clr_ovf(clr[0])
  );

  fir_decim_buffer #(.DECIM(1), .DEPTH(4)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]),
    .out_valid(ov1), .out_ready(rd[1]), .out_data(od1), .level(lv1),
    .overflow(of1), .drop_cnt(dc1), .clr_ovf(clr[1])
  );

  int tests = 0;
  int fails = 0;

  // Reference: count valid samples since reset, keep by index, FIFO as a ring of values.
  int          mcnt [2];
  longint      msum [2];
  logic [15:0] mf [2][16];
  int          mhead [2];
  int          msize [2];
  logic        movf [2];
  int          mdc [2];
  logic [15:0] got0 [$];

  function automatic int dec_of(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic longint fdiv(input longint s, input int d);
    longint q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; msum[k] = 0; mhead[k] = 0; msize[k] = 0;
      movf[k] = 1'b0; mdc[k] = 0;
    end
  endtask

  task automatic model_upd(input int k);
    int          d, p;
    logic        pop, keep, drop;
    logic [15:0] val;
    d = dec_of(k); p = depth_of(k);
    pop = (msize[k] > 0) && rd[k];
    keep = 1'b0; drop = 1'b0; val = 16'h0;
    if (iv[k]) begin
`ifdef FIR_DECIM_AVG_EN
      msum[k] += longint'($signed(id[k]));
      if (mcnt[k] % d == d - 1) begin
        keep = 1'b1;
        val = 16'(fdiv(msum[k], d));
        msum[k] = 0;
      end
`else
      if (mcnt[k] % d == 0) begin
        keep = 1'b1;
        val = id[k];
      end
`endif
      mcnt[k]++;
    end
    if (pop) begin
      if (k == 0) got0.push_back(mf[k][mhead[k]]);
      mhead[k] = (mhead[k] + 1) % p;
      msize[k]--;
    end
    if (keep) begin
      if (msize[k] < p) begin
        mf[k][(mhead[k] + msize[k]) % p] = val;
        msize[k]++;
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) begin
      movf[k] = 1'b1;
      mdc[k] = clr[k] ? 1 : ((mdc[k] == 65535) ? 65535 : mdc[k] + 1);
    end else if (clr[k]) begin
      movf[k] = 1'b0;
      mdc[k] = 0;
    end
  endtask

  task automatic check_all();
    logic        ev;
    logic [15:0] ed;
    ev = msize[0] > 0; ed = ev ? mf[0][mhead[0]] : 16'h0;
    check("out_valid0", ov0, ev);
    check("out_data0", od0, ed);
    check("level0", lv0, msize[0]);
    check("overflow0", of0, movf[0]);
    check("drop_cnt0", dc0, mdc[0]);
    ev = msize[1] > 0; ed = ev ? mf[1][mhead[1]] : 16'h0;
    check("out_valid1", ov1, ev);
    check("out_data1", od1, ed);
    check("level1", lv1, msize[1]);
    check("overflow1", of1, movf[1]);
    check("drop_cnt1", dc1, mdc[1]);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) mreset();
    else begin
      model_upd(0);
      model_upd(1);
    end
    #1;
    check_all();
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; rd[k] = 1'b0; clr[k] = 1'b0; id[k] = 16'h0;
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    mreset();
    step();
    step();
    check("reset_level0", lv0, 0);
    check("reset_out_data1", od1, 0);
    rst = 1'b0;

    // Stream 1..12 into d0 with the consumer always ready.
    for (int i = 1; i <= 12; i++) begin
      iv[0] = 1'b1; id[0] = 16'(i); rd[0] = 1'b1;
      step();
      check("t1_level_le1", lv0 <= 5'd1, 1'b1);
    end
    iv[0] = 1'b0;
    step(); step();
    check("t1_count", got0.size(), 3);
`ifdef FIR_DECIM_AVG_EN
    check("t1_v0", got0[0], 16'd2);
    check("t1_v1", got0[1], 16'd6);
    check("t1_v2", got0[2], 16'd10);
`else
    check("t1_v0", got0[0], 16'd1);
    check("t1_v1", got0[1], 16'd5);
    check("t1_v2", got0[2], 16'd9);
`endif
    check("t1_ovf", of0, 1'b0);
    rd[0] = 1'b0;

    // d1: six samples into a depth-4 FIFO with no consumer.
    for (int i = 0; i < 6; i++) begin
      iv[1] = 1'b1; id[1] = 16'h0100 + 16'(i);
      step();
    end
    iv[1] = 1'b0;
    check("t2_level", lv1, 3'd4);
    check("t2_ovf", of1, 1'b1);
    check("t2_drops", dc1, 16'd2);
    rd[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_order", od1, 16'h0100 + 16'(i));
      step();
    end
    check("t2_empty", ov1, 1'b0);

    // Full FIFO, push coincides with pop.
    rd[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      iv[1] = 1'b1; id[1] = 16'h0200 + 16'(i);
      step();
    end
    id[1] = 16'h02AA; rd[1] = 1'b1;
    step();
    iv[1] = 1'b0;
    check("t3_level", lv1, 3'd4);
    check("t3_drops", dc1, 16'd2);
    step(); step(); step();
    check("t3_last", od1, 16'h02AA);
    step();
    check("t3_empty", ov1, 1'b0);

    // clr_ovf alone, then together with a drop.
    rd[1] = 1'b0; clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    check("t4_ovf_clr", of1, 1'b0);
    check("t4_cnt_clr", dc1, 16'd0);
    for (int i = 0; i < 4; i++) begin
      iv[1] = 1'b1; id[1] = 16'h0300 + 16'(i);
      step();
    end
    id[1] = 16'h03FF; clr[1] = 1'b1;
    step();
    iv[1] = 1'b0; clr[1] = 1'b0;
    check("t4_ovf_set", of1, 1'b1);
    check("t4_cnt_one", dc1, 16'd1);
    rd[1] = 1'b1;
    repeat (5) step();

`ifdef FIR_DECIM_AVG_EN
    // d0 phase is back at zero after 12 samples.
    rd[0] = 1'b0; iv[0] = 1'b1;
    id[0] = 16'hF000; step();
    id[0] = 16'hF000; step();
    id[0] = 16'h1000; step();
    id[0] = 16'hFFFF; step();
    check("t5_level", lv0, 5'd1);
    check("t5_avg_neg", od0, 16'hFBFF);
    id[0] = 16'd4; step(); step(); step();
    id[0] = 16'd5; step();
    iv[0] = 1'b0; rd[0] = 1'b1;
    step();
    check("t5_avg_pos", od0, 16'd4);
    step();
    rd[0] = 1'b0;
`endif

    // Random traffic: a congested phase, then a draining phase.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k]  = ($urandom % 4) != 0;
        id[k]  = 16'($urandom);
        rd[k]  = (i < 200) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
        clr[k] = ($urandom % 32) == 0;
      end
      step();
    end
    idle();

    // Asynchronous reset mid-stream on a clean d0 state.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1'b1; id[0] = 16'h0400 + 16'(i);
      step();
    end
    iv[0] = 1'b0;
`ifdef FIR_DECIM_AVG_EN
    check("t7_pre_level", lv0, 5'd2);
`else
    check("t7_pre_level", lv0, 5'd3);
`endif
    #3;
    rst = 1'b1;
    #1;
    mreset();
    check("t7_async_valid", ov0, 1'b0);
    check("t7_async_level", lv0, 5'd0);
    check("t7_async_data", od0, 16'h0);
    step();
    rst = 1'b0;
    iv[0] = 1'b1; id[0] = 16'h1234;
    step();
    iv[0] = 1'b0;
`ifdef FIR_DECIM_AVG_EN
    check("t7_first_kept", lv0, 5'd0);
`else
    check("t7_first_kept", od0, 16'h1234);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
